// File: rtl/mux_switch_sequencer.sv
// rtl/mux_switch_sequencer.sv - request/ack sequencer driving top_design_mux select and resets
// Optional feature macro: MUX_SEQ_LOCK_EN (adds i_lock and a sticky lock register).
module mux_switch_sequencer #(
    parameter logic [3:0] PARK_ID       = 4'd15,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         RESET_CYCLES  = 8,
    parameter int         CNT_W         = 8
) (
    input  logic       wb_clk_i,
    input  logic       rst_n,
`ifdef MUX_SEQ_LOCK_EN
    input  logic       i_lock,
`endif
    input  logic       i_req,
    input  logic [3:0] i_target,
    input  logic       i_hold_rst,
    input  logic       i_sys_reset_enb,
    input  logic       i_io5_reset_enb,
    input  logic       i_auto_reset_enb,
    output logic [3:0] o_mux_sel,
    output logic       o_mux_sys_reset_enb,
    output logic       o_mux_io5_reset_enb,
    output logic       o_mux_auto_reset_enb,
    output logic [7:0] o_design_reset,
    output logic [3:0] o_active_id,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_dropped
);

    typedef enum logic [2:0] {
        S_IDLE, S_ASSERT, S_PARK, S_SELECT, S_HOLD_LOAD, S_HOLD, S_RELEASE, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LOAD  = CNT_W'(RESET_CYCLES - 1);

    state_t           state, state_nxt;
    logic             req_q;
    logic [3:0]       tgt;
    logic             hold;
    logic [CNT_W-1:0] cnt;
    logic             cnt_live;
    logic             locked;
    logic             req_edge;
    logic             accept;

    // IDs 8..15 have no per-design reset line.
    function automatic logic [7:0] id_bit(input logic [3:0] id);
        id_bit = id[3] ? 8'h00 : (8'h01 << id[2:0]);
    endfunction

    assign req_edge = i_req & ~req_q;
    assign accept   = req_edge && (state == S_IDLE) && !locked;
    assign o_busy   = (state != S_IDLE) && (state != S_DONE);
    assign o_done   = (state == S_DONE);

`ifdef MUX_SEQ_LOCK_EN
    always_ff @(posedge wb_clk_i) begin
        if (!rst_n)
            locked <= 1'b0;
        else if (i_lock && state == S_IDLE)
            locked <= 1'b1;
    end
`else
    assign locked = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (accept) state_nxt = S_ASSERT;
            S_ASSERT:    state_nxt = (tgt == o_active_id) ? S_HOLD_LOAD : S_PARK;
            S_PARK:      if (cnt_live && cnt == '0) state_nxt = S_SELECT;
            S_SELECT:    if (cnt_live && cnt == '0) state_nxt = S_HOLD_LOAD;
            S_HOLD_LOAD: state_nxt = S_HOLD;
            S_HOLD:      if (cnt == '0) state_nxt = S_RELEASE;
            S_RELEASE:   state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            req_q                <= 1'b0;
            tgt                  <= PARK_ID;
            hold                 <= 1'b0;
            cnt                  <= '0;
            cnt_live             <= 1'b0;
            o_mux_sel            <= PARK_ID;
            o_active_id          <= PARK_ID;
            o_design_reset       <= 8'hFF;
            o_mux_sys_reset_enb  <= 1'b0;
            o_mux_io5_reset_enb  <= 1'b1;
            o_mux_auto_reset_enb <= 1'b0;
            o_dropped            <= 1'b0;
        end else begin
            req_q                <= i_req;
            o_mux_sys_reset_enb  <= i_sys_reset_enb;
            o_mux_io5_reset_enb  <= i_io5_reset_enb;
            o_mux_auto_reset_enb <= i_auto_reset_enb;
            if (accept) begin
                tgt       <= i_target;
                hold      <= i_hold_rst;
                o_dropped <= 1'b0;
            end else if (req_edge) begin
                o_dropped <= 1'b1;
            end
            // PARK and SELECT register their output and load the counter on
            // their first cycle, then count the settle window down.
            case (state)
                S_ASSERT: begin
                    o_design_reset <= o_design_reset | id_bit(o_active_id) | id_bit(tgt);
                    cnt_live       <= 1'b0;
                end
                S_PARK, S_SELECT: begin
                    if (!cnt_live) begin
                        cnt      <= SETTLE_LOAD;
                        cnt_live <= 1'b1;
                        if (state == S_PARK) begin
                            o_mux_sel <= PARK_ID;
                        end else begin
                            o_mux_sel   <= tgt;
                            o_active_id <= tgt;
                        end
                    end else if (cnt == '0) begin
                        cnt_live <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD_LOAD: cnt <= RESET_LOAD;
                S_HOLD:      if (cnt != '0) cnt <= cnt - 1'b1;
                S_RELEASE: begin
                    if (!hold && !tgt[3])
                        o_design_reset[tgt[2:0]] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_switch_sequencer.sv
// tb/tb_mux_switch_sequencer.sv - scoreboard bench for mux_switch_sequencer
module tb_mux_switch_sequencer;

    localparam int S        = 4;
    localparam int R        = 8;
    localparam int LAT_FULL = 2 * S + R + 5;
    localparam int LAT_SAME = R + 3;

    logic       wb_clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_req = 1'b0;
    logic [3:0] i_target = 4'd0;
    logic       i_hold_rst = 1'b0;
    logic       i_sys_reset_enb = 1'b0;
    logic       i_io5_reset_enb = 1'b1;
    logic       i_auto_reset_enb = 1'b0;
    logic [3:0] o_mux_sel;
    logic       o_mux_sys_reset_enb, o_mux_io5_reset_enb, o_mux_auto_reset_enb;
    logic [7:0] o_design_reset;
    logic [3:0] o_active_id;
    logic       o_busy, o_done, o_dropped;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         lat;
        logic [7:0] dr;
        logic [3:0] active;
    } exp_t;
    exp_t sb_q[$];

    always #5 wb_clk_i = ~wb_clk_i;

    mux_switch_sequencer #(
        .PARK_ID(4'd15), .SETTLE_CYCLES(S), .RESET_CYCLES(R), .CNT_W(8)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .rst_n(rst_n),
`ifdef MUX_SEQ_LOCK_EN
        .i_lock(1'b0),
`endif
        .i_req(i_req),
        .i_target(i_target),
        .i_hold_rst(i_hold_rst),
        .i_sys_reset_enb(i_sys_reset_enb),
        .i_io5_reset_enb(i_io5_reset_enb),
        .i_auto_reset_enb(i_auto_reset_enb),
        .o_mux_sel(o_mux_sel),
        .o_mux_sys_reset_enb(o_mux_sys_reset_enb),
        .o_mux_io5_reset_enb(o_mux_io5_reset_enb),
        .o_mux_auto_reset_enb(o_mux_auto_reset_enb),
        .o_design_reset(o_design_reset),
        .o_active_id(o_active_id),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_dropped(o_dropped)
    );

    // Select-line watcher: no direct ID-to-ID hop, and parking lasts long enough.
    logic [3:0] sel_prev = 4'd15;
    int         park_run = 0;
    int         sel_changes = 0;
    always @(negedge wb_clk_i) begin
        if (o_mux_sel != sel_prev) begin
            sel_changes = sel_changes + 1;
            checks = checks + 1;
            if (sel_prev != 4'd15 && o_mux_sel != 4'd15) begin
                errors = errors + 1;
                $display("FAIL sel_direct: sel went %0d -> %0d, required via 15", sel_prev, o_mux_sel);
            end else if (sel_prev == 4'd15 && park_run < S) begin
                errors = errors + 1;
                $display("FAIL park_short: parked %0d cycles, required >= %0d", park_run, S);
            end
            park_run = 0;
        end
        if (o_mux_sel == 4'd15) park_run = park_run + 1;
        sel_prev = o_mux_sel;
    end

    task automatic start_req(input logic [3:0] target, input logic hold_rst);
        @(negedge wb_clk_i);
        i_target   = target;
        i_hold_rst = hold_rst;
        i_req      = 1'b1;
        @(posedge wb_clk_i);
    endtask

    // Observation k is taken at the negedge following accept edge + k.
    task automatic wait_done(input int drop_k, output int lat, output logic [7:0] dr_k1,
                             output logic busy_k0, output bit timed_out);
        int k;
        @(negedge wb_clk_i);
        k = 0;
        i_req = 1'b0;
        busy_k0 = o_busy;
        dr_k1 = 8'h00;
        timed_out = 1'b0;
        while (!o_done && k < 200) begin
            @(negedge wb_clk_i);
            k = k + 1;
            if (k == 1) dr_k1 = o_design_reset;
            if (k == drop_k) i_req = 1'b1;
            if (k == drop_k + 1) i_req = 1'b0;
        end
        lat = k;
        if (!o_done) timed_out = 1'b1;
    endtask

    task automatic check_txn(input string name, input int lat, input bit timed_out);
        exp_t e;
        e = sb_q.pop_front();
        checks = checks + 3;
        if (timed_out || lat !== e.lat) begin
            errors = errors + 1;
            $display("FAIL %s_latency: got %0d (timeout=%0d), required %0d", name, lat, timed_out, e.lat);
        end
        if (o_design_reset !== e.dr) begin
            errors = errors + 1;
            $display("FAIL %s_design_reset: got %h, required %h", name, o_design_reset, e.dr);
        end
        if (o_active_id !== e.active || o_mux_sel !== e.active) begin
            errors = errors + 1;
            $display("FAIL %s_active: active %0d sel %0d, required %0d", name, o_active_id, o_mux_sel, e.active);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        rst_n = 1'b1;
        repeat (5) @(negedge wb_clk_i);
        checks = checks + 1;
        if (o_mux_sel !== 4'd15 || o_active_id !== 4'd15 || o_design_reset !== 8'hFF ||
            o_busy !== 1'b0 || o_done !== 1'b0 || o_dropped !== 1'b0 ||
            o_mux_sys_reset_enb !== 1'b0 || o_mux_io5_reset_enb !== 1'b1 || o_mux_auto_reset_enb !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_values: sel %0d act %0d dr %h busy %b done %b drop %b enb %b%b%b, required 15 15 ff 0 0 0 010",
                     o_mux_sel, o_active_id, o_design_reset, o_busy, o_done, o_dropped,
                     o_mux_sys_reset_enb, o_mux_io5_reset_enb, o_mux_auto_reset_enb);
        end
    endtask

    task automatic test_enb_passthrough();
        @(negedge wb_clk_i);
        i_sys_reset_enb = 1'b1; i_io5_reset_enb = 1'b0; i_auto_reset_enb = 1'b1;
        #1;
        checks = checks + 2;
        if ({o_mux_sys_reset_enb, o_mux_io5_reset_enb, o_mux_auto_reset_enb} !== 3'b010) begin
            errors = errors + 1;
            $display("FAIL enb_early: got %b, required 010 before the edge",
                     {o_mux_sys_reset_enb, o_mux_io5_reset_enb, o_mux_auto_reset_enb});
        end
        @(negedge wb_clk_i);
        if ({o_mux_sys_reset_enb, o_mux_io5_reset_enb, o_mux_auto_reset_enb} !== 3'b101) begin
            errors = errors + 1;
            $display("FAIL enb_pass: got %b, required 101",
                     {o_mux_sys_reset_enb, o_mux_io5_reset_enb, o_mux_auto_reset_enb});
        end
        i_sys_reset_enb = 1'b0; i_io5_reset_enb = 1'b1; i_auto_reset_enb = 1'b0;
    endtask

    task automatic test_first_switch();
        int lat; logic [7:0] dr1; logic b0; bit to;
        sb_q.push_back('{lat: LAT_FULL, dr: 8'hFE, active: 4'd0});
        start_req(4'd0, 1'b0);
        wait_done(-10, lat, dr1, b0, to);
        checks = checks + 1;
        if (b0 !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL first_busy: got %b after accept, required 1", b0);
        end
        check_txn("first", lat, to);
        @(negedge wb_clk_i);
        checks = checks + 1;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL done_pulse: done %b busy %b one cycle later, required 0 0", o_done, o_busy);
        end
    endtask

    task automatic test_switch_3();
        int lat; logic [7:0] dr1; logic b0; bit to;
        sb_q.push_back('{lat: LAT_FULL, dr: 8'hF7, active: 4'd3});
        start_req(4'd3, 1'b0);
        wait_done(-10, lat, dr1, b0, to);
        checks = checks + 1;
        if ((dr1 & 8'h09) !== 8'h09) begin
            errors = errors + 1;
            $display("FAIL assert_bits: got %h after ASSERT, required bits 0 and 3 set", dr1);
        end
        check_txn("switch3", lat, to);
    endtask

    task automatic test_same_target_hold();
        int lat; logic [7:0] dr1; logic b0; bit to; int sc;
        sc = sel_changes;
        sb_q.push_back('{lat: LAT_SAME, dr: 8'hFF, active: 4'd3});
        start_req(4'd3, 1'b1);
        wait_done(-10, lat, dr1, b0, to);
        check_txn("same", lat, to);
        checks = checks + 1;
        if (sel_changes !== sc) begin
            errors = errors + 1;
            $display("FAIL same_sel_moved: %0d sel changes, required 0", sel_changes - sc);
        end
    endtask

    task automatic test_drop_during_hold();
        int lat; logic [7:0] dr1; logic b0; bit to;
        sb_q.push_back('{lat: LAT_FULL, dr: 8'hDF, active: 4'd5});
        start_req(4'd5, 1'b0);
        wait_done(2 * S + 5, lat, dr1, b0, to);
        check_txn("drop", lat, to);
        checks = checks + 1;
        if (o_dropped !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL dropped_set: got %b, required 1", o_dropped);
        end
        sb_q.push_back('{lat: LAT_FULL, dr: 8'hFD, active: 4'd1});
        start_req(4'd1, 1'b0);
        wait_done(-10, lat, dr1, b0, to);
        check_txn("after_drop", lat, to);
        checks = checks + 1;
        if (o_dropped !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL dropped_clear: got %b, required 0", o_dropped);
        end
    endtask

    task automatic test_reset_mid_select();
        int lat; logic [7:0] dr1; logic b0; bit to;
        start_req(4'd6, 1'b0);
        @(negedge wb_clk_i);
        i_req = 1'b0;
        repeat (S + 3) @(negedge wb_clk_i);
        rst_n = 1'b0;
        @(negedge wb_clk_i);
        checks = checks + 1;
        if (o_mux_sel !== 4'd15 || o_active_id !== 4'd15 || o_design_reset !== 8'hFF ||
            o_busy !== 1'b0 || o_done !== 1'b0 || o_dropped !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL abort_values: sel %0d act %0d dr %h busy %b done %b drop %b, required 15 15 ff 0 0 0",
                     o_mux_sel, o_active_id, o_design_reset, o_busy, o_done, o_dropped);
        end
        rst_n = 1'b1;
        sb_q.push_back('{lat: LAT_FULL, dr: 8'hFB, active: 4'd2});
        start_req(4'd2, 1'b0);
        wait_done(-10, lat, dr1, b0, to);
        check_txn("post_abort", lat, to);
    endtask

    task automatic test_park_target();
        int lat; logic [7:0] dr1; logic b0; bit to;
        sb_q.push_back('{lat: LAT_FULL, dr: 8'hFF, active: 4'd15});
        start_req(4'd15, 1'b0);
        wait_done(-10, lat, dr1, b0, to);
        check_txn("park_tgt", lat, to);
    endtask

    initial begin
        test_reset();
        test_enb_passthrough();
        test_first_switch();
        test_switch_3();
        test_same_target_hold();
        test_drop_during_hold();
        test_reset_mid_select();
        test_park_target();
        repeat (3) @(negedge wb_clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
